mem_port_arbiter: RTL and testbench

Shares the single unified memory port of the multicycle RV32I core between two requesters: the instruction-fetch path (FETCH-state reads at the PC) and the load/store path (MEMREAD/MEMWRITE accesses at the ALU result). It sits between the datapath's address/write-data muxing and the memory, serialises one transaction at a time with round-robin fairness, and returns each response only to the requester that issued it. The control FSM stalls on the per-requester grant and response pulses instead of assuming fixed single-cycle memory.

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status signals of mem_port_arbiter.
// The arbiter connects through the slave modport; the core/memory side uses master.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_adr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic [31:0] ls_adr;
    logic [3:0]  ls_we;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;

    logic        mem_req;
    logic [31:0] mem_adr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        busy;
    logic        owner;
    logic        timeout_err;

    modport slave (
        input  if_req, if_adr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_adr, ls_we, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_adr, mem_we, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output busy, owner, timeout_err
    );

    modport master (
        output if_req, if_adr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_adr, ls_we, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_adr, mem_we, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  busy, owner, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Optional response timeout is compiled in with MEM_PORT_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e      state_q;
    logic        owner_q;
    logic        last_owner_q;
    logic [31:0] adr_q;
    logic [3:0]  we_q;
    logic [31:0] wdata_q;
    logic        if_rvalid_q;
    logic        ls_rvalid_q;
    logic [31:0] if_rdata_q;
    logic [31:0] ls_rdata_q;
    logic        err_q;

    logic        sel_ls_d;
    logic        accept;
    logic        expired;

    // On a tie the requester that did not own the previous transaction wins.
    always_comb begin
        sel_ls_d = bus.ls_req && (!bus.if_req || !last_owner_q);
    end

    assign accept = (state_q == ST_ISSUE) && bus.mem_ready;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == ST_WAIT && !bus.mem_rvalid) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Last silent WAIT cycle; a response in this same cycle still wins.
    assign expired = (cnt_q == CNT_LAST);
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: every register, including the datapath copies, resets so all outputs read 0.
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            adr_q        <= '0;
            we_q         <= '0;
            wdata_q      <= '0;
            if_rvalid_q  <= 1'b0;
            ls_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make response strobes single-cycle pulses.
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            err_q       <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.if_req || bus.ls_req) begin
                        owner_q <= sel_ls_d;
                        adr_q   <= sel_ls_d ? bus.ls_adr   : bus.if_adr;
                        we_q    <= sel_ls_d ? bus.ls_we    : 4'b0000;
                        wdata_q <= sel_ls_d ? bus.ls_wdata : 32'h0;
                        state_q <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (bus.mem_ready) begin
                        last_owner_q <= owner_q;
                        state_q      <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (bus.mem_rvalid) begin
                        state_q <= ST_IDLE;
                        if (owner_q) begin
                            ls_rvalid_q <= 1'b1;
                            ls_rdata_q  <= (we_q == 4'b0000) ? bus.mem_rdata : 32'h0;
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= bus.mem_rdata;
                        end
                    end else if (expired) begin
                        state_q     <= ST_IDLE;
                        err_q       <= 1'b1;
                        if_rvalid_q <= !owner_q;
                        ls_rvalid_q <= owner_q;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_req     = (state_q == ST_ISSUE);
    assign bus.mem_adr     = adr_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_wdata   = wdata_q;

    assign bus.if_gnt      = accept && !owner_q;
    assign bus.ls_gnt      = accept &&  owner_q;
    assign bus.if_rvalid   = if_rvalid_q;
    assign bus.ls_rvalid   = ls_rvalid_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.ls_rdata    = ls_rdata_q;

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.owner       = owner_q;
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of arbitration and response routing.
module tb_mem_port_arbiter;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Model state: who owned the last granted transaction, which requests are pending.
    logic m_last_owner;
    bit   pend_if;
    bit   pend_ls;

    function automatic logic [139:0] all_outs();
        return {bus.if_gnt, bus.if_rvalid, bus.if_rdata,
                bus.ls_gnt, bus.ls_rvalid, bus.ls_rdata,
                bus.mem_req, bus.mem_adr, bus.mem_we, bus.mem_wdata,
                bus.busy, bus.owner, bus.timeout_err};
    endfunction

    task automatic zero_inputs();
        bus.if_req     = 1'b0;
        bus.if_adr     = 32'h0;
        bus.ls_req     = 1'b0;
        bus.ls_adr     = 32'h0;
        bus.ls_we      = 4'b0;
        bus.ls_wdata   = 32'h0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        pend_if        = 1'b0;
        pend_ls        = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        zero_inputs();
        m_last_owner = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic raise_if(input logic [31:0] adr);
        bus.if_req = 1'b1;
        bus.if_adr = adr;
        pend_if    = 1'b1;
    endtask

    task automatic raise_ls(input logic [31:0] adr, input logic [3:0] we, input logic [31:0] wd);
        bus.ls_req   = 1'b1;
        bus.ls_adr   = adr;
        bus.ls_we    = we;
        bus.ls_wdata = wd;
        pend_ls      = 1'b1;
    endtask

    // Runs one transaction from an IDLE cycle with requests already driven.
    // Leaves the bench at the negedge of the response cycle.
    task automatic issue_txn(input int rdy_dly, input int rsp_dly,
                             input logic [31:0] rd, output logic eo);
        logic [31:0] eadr, ewd, erd;
        logic [3:0]  ewe;
        logic [43:0] act, exp;
        logic [7:0]  wact, wexp;
        logic [72:0] ract, rexp;

        eo   = (pend_if && pend_ls) ? ~m_last_owner : logic'(pend_ls);
        eadr = eo ? bus.ls_adr : bus.if_adr;
        ewe  = eo ? bus.ls_we : 4'b0000;
        ewd  = bus.ls_wdata;
        erd  = (eo && ewe != 4'b0000) ? 32'h0 : rd;

        @(posedge clk); #1;
        for (int i = 0; i < rdy_dly; i++) begin
            bus.mem_ready = 1'b0;
            @(negedge clk);
            act = {bus.mem_req, bus.busy, bus.owner, bus.if_gnt, bus.ls_gnt,
                   bus.if_rvalid, bus.ls_rvalid, bus.timeout_err, bus.mem_adr, bus.mem_we};
            exp = {1'b1, 1'b1, eo, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, eadr, ewe};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL issue_stall cyc=%0d: got %h expected %h", i, act, exp);
            end
            @(posedge clk); #1;
        end

        bus.mem_ready = 1'b1;
        @(negedge clk);
        act = {bus.mem_req, bus.busy, bus.owner, bus.if_gnt, bus.ls_gnt,
               bus.if_rvalid, bus.ls_rvalid, bus.timeout_err, bus.mem_adr, bus.mem_we};
        exp = {1'b1, 1'b1, eo, ~eo, eo, 1'b0, 1'b0, 1'b0, eadr, ewe};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL grant: got %h expected %h", act, exp);
        end
        if (eo) begin
            total++;
            if (bus.mem_wdata !== ewd) begin
                bad++;
                $display("FAIL mem_wdata: got %h expected %h", bus.mem_wdata, ewd);
            end
        end

        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        if (eo) begin
            bus.ls_req = 1'b0;
            pend_ls    = 1'b0;
        end else begin
            bus.if_req = 1'b0;
            pend_if    = 1'b0;
        end
        m_last_owner = eo;

        for (int i = 0; i < rsp_dly; i++) begin
            @(negedge clk);
            wact = {bus.mem_req, bus.busy, bus.owner, bus.if_gnt, bus.ls_gnt,
                    bus.if_rvalid, bus.ls_rvalid, bus.timeout_err};
            wexp = {1'b0, 1'b1, eo, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            total++;
            if (wact !== wexp) begin
                bad++;
                $display("FAIL wait cyc=%0d: got %b expected %b", i, wact, wexp);
            end
            @(posedge clk); #1;
        end

        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rd;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
        @(negedge clk);
        ract = {bus.busy, bus.if_rvalid, bus.ls_rvalid, bus.if_rdata, bus.ls_rdata,
                bus.timeout_err, bus.if_gnt, bus.ls_gnt, bus.mem_req};
        rexp = {1'b0, ~eo, eo, (eo ? 32'h0 : erd), (eo ? erd : 32'h0),
                1'b0, 1'b0, 1'b0, 1'b0};
        total++;
        if (ract !== rexp) begin
            bad++;
            $display("FAIL response owner=%0b: got %h expected %h", eo, ract, rexp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if (all_outs() !== 140'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
    endtask

    task automatic test_fetch_only();
        logic eo;
        do_reset();
        raise_if(32'h0000_0100);
        issue_txn(0, 1, 32'h0050_0093, eo);
        total++;
        if (bus.if_rdata !== 32'h0050_0093) begin
            bad++;
            $display("FAIL fetch_rdata: got %h expected 00500093", bus.if_rdata);
        end
    endtask

    task automatic test_tie_first();
        logic eo;
        do_reset();
        raise_if(32'h0000_0200);
        raise_ls(32'h0000_1004, 4'b0011, 32'hDEAD_BEEF);
        issue_txn(0, 0, 32'h1111_2222, eo);
        total++;
        if (bus.owner !== 1'b0) begin
            bad++;
            $display("FAIL tie_first_owner: got %b expected 0", bus.owner);
        end
        issue_txn(0, 0, 32'h3333_4444, eo);
        total++;
        if ({bus.owner, bus.mem_we, bus.mem_wdata, bus.ls_rdata} !== {1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h0}) begin
            bad++;
            $display("FAIL tie_store: got owner=%b we=%b wdata=%h rdata=%h", bus.owner, bus.mem_we,
                     bus.mem_wdata, bus.ls_rdata);
        end
    endtask

    task automatic test_alternate();
        logic eo;
        do_reset();
        raise_if(32'h0000_0300);
        raise_ls(32'h0000_2000, 4'b0000, 32'h0);
        for (int k = 0; k < 6; k++) begin
            issue_txn(0, 0, $urandom, eo);
            total++;
            if (bus.owner !== logic'(k % 2)) begin
                bad++;
                $display("FAIL alternate k=%0d: got owner %b expected %0d", k, bus.owner, k % 2);
            end
            if (eo) raise_ls(32'h0000_2000 + 32'(4 * k), 4'b0000, 32'h0);
            else    raise_if(32'h0000_0300 + 32'(4 * k));
        end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        pend_if    = 1'b0;
        pend_ls    = 1'b0;
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_ready_stall();
        logic eo;
        do_reset();
        raise_if(32'h0000_0ABC);
        issue_txn(5, 1, 32'hCAFE_F00D, eo);
    endtask

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [35:0] act, exp;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            raise_ls(32'h0000_4000, 4'b0000, 32'h0);
            @(posedge clk); #1;
            bus.mem_ready = 1'b1;
            @(negedge clk);
            total++;
            if (bus.ls_gnt !== 1'b1) begin
                bad++;
                $display("FAIL timeout_grant pass=%0d: got %b expected 1", pass, bus.ls_gnt);
            end
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
            bus.ls_req    = 1'b0;
            pend_ls       = 1'b0;
            for (int i = 0; i < TO; i++) begin
                if (pass == 1 && i == TO - 1) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = 32'h5A5A_0001;
                end
                @(negedge clk);
                total++;
                if ({bus.busy, bus.timeout_err, bus.ls_rvalid} !== 3'b100) begin
                    bad++;
                    $display("FAIL timeout_wait pass=%0d cyc=%0d: got %b expected 100", pass, i,
                             {bus.busy, bus.timeout_err, bus.ls_rvalid});
                end
                @(posedge clk); #1;
            end
            bus.mem_rvalid = 1'b0;
            @(negedge clk);
            act = {bus.timeout_err, bus.ls_rvalid, bus.ls_rdata, bus.busy, bus.if_rvalid};
            exp = (pass == 0) ? {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}
                              : {1'b0, 1'b1, 32'h5A5A_0001, 1'b0, 1'b0};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL timeout_end pass=%0d: got %h expected %h", pass, act, exp);
            end
        end
    endtask
`else
    task automatic test_timeout();
        logic eo;
        do_reset();
        raise_ls(32'h0000_4000, 4'b0000, 32'h0);
        issue_txn(0, 20, 32'h5A5A_0002, eo);
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        raise_if(32'h0000_0500);
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        bus.if_req    = 1'b0;
        pend_if       = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL midreset_in_wait: got busy %b expected 1", bus.busy);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (all_outs() !== 140'h0) begin
            bad++;
            $display("FAIL midreset_outputs: got %h expected 0", all_outs());
        end
        @(posedge clk); #1;
        reset          = 1'b1;
        m_last_owner   = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (all_outs() !== 140'h0) begin
                bad++;
                $display("FAIL midreset_stray_rvalid cyc=%0d: got %h expected 0", i, all_outs());
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic eo;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if (!pend_if && $urandom_range(0, 1) == 1) raise_if($urandom);
            if (!pend_ls && $urandom_range(0, 1) == 1)
                raise_ls($urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000, $urandom);
            if (!pend_if && !pend_ls) begin
                if ($urandom_range(0, 1) == 1) raise_if($urandom);
                else                           raise_ls($urandom, 4'b0000, $urandom);
            end
            issue_txn($urandom_range(0, 2), $urandom_range(0, 3), $urandom, eo);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch_only();
        test_tie_first();
        test_alternate();
        test_ready_stall();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
